regfile_wb_arbiter: RTL and testbench

Write-back arbiter that owns the single write port of the integer register file. It merges one-per-cycle ALU results with variable-latency load results, buffering loads in a small FIFO. It drives the register file's write index, data and enable from registered outputs. It also gives the decode stage a "pending write" check so reads of a register with an outstanding write stall instead of returning stale data.

---
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: single register-file write port shared by one-per-cycle ALU results and FIFO-buffered load results
//   clk, rst_n              clock, async active-low reset
//   i_alu_* / o_alu_ready   ALU result handshake
//   i_lsu_* / o_lsu_ready   load result handshake into the load FIFO
//   o_wb_reg/data/en        registered register-file write port
//   i_chk_regN/o_chk_busyN  decode-stage pending-write check
//   o_lq_count              load FIFO occupancy
module regfile_wb_arbiter #(
  parameter int RAW      = 5,
  parameter int DW       = 32,
  parameter int LQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_alu_valid,
  output logic                        o_alu_ready,
  input  logic [RAW-1:0]              i_alu_rd,
  input  logic [DW-1:0]               i_alu_data,
  input  logic                        i_lsu_valid,
  output logic                        o_lsu_ready,
  input  logic [RAW-1:0]              i_lsu_rd,
  input  logic [DW-1:0]               i_lsu_data,
  output logic [RAW-1:0]              o_wb_reg,
  output logic [DW-1:0]               o_wb_data,
  output logic                        o_wb_en,
  input  logic [RAW-1:0]              i_chk_reg1,
  input  logic [RAW-1:0]              i_chk_reg2,
  output logic                        o_chk_busy1,
  output logic                        o_chk_busy2,
  output logic [$clog2(LQ_DEPTH):0]   o_lq_count
);
  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;
  logic [RAW-1:0] rd_mem [LQ_DEPTH];
  logic [DW-1:0]  data_mem [LQ_DEPTH];
  logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           wb_en_q, wb_en_d;
  logic [RAW-1:0] wb_reg_q, wb_reg_d, sel_rd;
  logic [DW-1:0]  wb_data_q, wb_data_d, sel_data;
  logic           full, empty, push, pop, take_alu, sel;
  logic [LQ_DEPTH-1:0] hit1, hit2;
  assign full        = cnt_q == CW'(LQ_DEPTH);
  assign empty       = cnt_q == '0;
  assign o_alu_ready = !full;
  assign o_lsu_ready = !full;
  assign o_lq_count  = cnt_q;
  assign o_wb_en     = wb_en_q;
  assign o_wb_reg    = wb_reg_q;
  assign o_wb_data   = wb_data_q;
  // A full FIFO always wins the slot so loads cannot starve behind a streaming ALU.
  always_comb begin
    push      = i_lsu_valid && !full;
    take_alu  = i_alu_valid && !full;
    pop       = full || (!i_alu_valid && !empty);
    sel       = pop || take_alu;
    sel_rd    = pop ? rd_mem[rptr_q] : i_alu_rd;
    sel_data  = pop ? data_mem[rptr_q] : i_alu_data;
    wptr_d    = wptr_q + PW'(push);
    rptr_d    = rptr_q + PW'(pop);
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    wb_en_d   = sel && (sel_rd != '0);
    wb_reg_d  = sel ? sel_rd : wb_reg_q;
    wb_data_d = sel ? sel_data : wb_data_q;
  end
  // Slot i is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      hit1[i] = ({1'b0, PW'(i) - rptr_q} < cnt_q) && (rd_mem[i] == i_chk_reg1);
      hit2[i] = ({1'b0, PW'(i) - rptr_q} < cnt_q) && (rd_mem[i] == i_chk_reg2);
    end
  end
  assign o_chk_busy1 = (i_chk_reg1 != '0) && (|hit1 || (wb_en_q && wb_reg_q == i_chk_reg1));
  assign o_chk_busy2 = (i_chk_reg2 != '0) && (|hit2 || (wb_en_q && wb_reg_q == i_chk_reg2));
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wptr_q]   <= i_lsu_rd;
      data_mem[wptr_q] <= i_lsu_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      wb_en_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      wb_en_q   <= wb_en_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scenario tasks with per-source write scoreboards for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_alu_valid = 1'b0, i_lsu_valid = 1'b0;
  logic [4:0]  i_alu_rd = '0, i_lsu_rd = '0, i_chk_reg1 = '0, i_chk_reg2 = '0;
  logic [31:0] i_alu_data = '0, i_lsu_data = '0;
  logic        o_alu_ready, o_lsu_ready, o_wb_en, o_chk_busy1, o_chk_busy2;
  logic [4:0]  o_wb_reg;
  logic [31:0] o_wb_data;
  logic [2:0]  o_lq_count;
  int errors = 0;
  int checks = 0;
  int cnt_m = 0;
  logic [36:0] alu_q[$];
  logic [36:0] lsu_q[$];

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready), .i_lsu_rd(i_lsu_rd), .i_lsu_data(i_lsu_data),
    .o_wb_reg(o_wb_reg), .o_wb_data(o_wb_data), .o_wb_en(o_wb_en),
    .i_chk_reg1(i_chk_reg1), .i_chk_reg2(i_chk_reg2),
    .o_chk_busy1(o_chk_busy1), .o_chk_busy2(o_chk_busy2), .o_lq_count(o_lq_count)
  );

  always #5 clk = ~clk;

  // Every enabled write must match the oldest outstanding result of one of the two sources.
  always @(negedge clk) begin
    if (rst_n && o_wb_en) begin
      checks++;
      if (alu_q.size() > 0 && alu_q[0] == {o_wb_reg, o_wb_data}) void'(alu_q.pop_front());
      else if (lsu_q.size() > 0 && lsu_q[0] == {o_wb_reg, o_wb_data}) void'(lsu_q.pop_front());
      else begin
        errors++;
        $display("FAIL wb_write: got reg=%0d data=%h, no matching expected write (alu pending=%0d lsu pending=%0d)",
                 o_wb_reg, o_wb_data, alu_q.size(), lsu_q.size());
      end
    end
  end

  // One clock cycle of stimulus; checks handshakes and occupancy against a small occupancy model.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
    logic full_m;
    i_alu_valid = av; i_alu_rd = ard; i_alu_data = adata;
    i_lsu_valid = lv; i_lsu_rd = lrd; i_lsu_data = ldata;
    #1;
    full_m = (cnt_m == 4);
    checks++;
    if (o_alu_ready !== !full_m) begin errors++; $display("FAIL alu_ready: got %b want %b", o_alu_ready, !full_m); end
    checks++;
    if (o_lsu_ready !== !full_m) begin errors++; $display("FAIL lsu_ready: got %b want %b", o_lsu_ready, !full_m); end
    checks++;
    if (o_lq_count !== 3'(cnt_m)) begin errors++; $display("FAIL lq_count: got %0d want %0d", o_lq_count, cnt_m); end
    if (av && !full_m && ard != 0) alu_q.push_back({ard, adata});
    if (lv && !full_m && lrd != 0) lsu_q.push_back({lrd, ldata});
    cnt_m = cnt_m + int'(lv && !full_m) - int'(full_m || (!av && cnt_m != 0));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && cnt_m != 0; k++) idle();
    idle();
    idle();
  endtask

  task automatic test_reset();
    i_chk_reg1 = 5'd5;
    i_chk_reg2 = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en: got %b want 0", o_wb_en); end
    checks++;
    if (o_lq_count !== 3'd0) begin errors++; $display("FAIL reset_lq_count: got %0d want 0", o_lq_count); end
    checks++;
    if (o_alu_ready !== 1'b1 || o_lsu_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got alu=%b lsu=%b want 1 1", o_alu_ready, o_lsu_ready);
    end
    checks++;
    if (o_chk_busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_chk_busy1); end
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_alu();
    i_chk_reg1 = 5'd5;
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    checks++;
    if (o_wb_en !== 1'b1 || o_wb_reg !== 5'd5 || o_wb_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL alu_write: got en=%b reg=%0d data=%h want 1 5 deadbeef", o_wb_en, o_wb_reg, o_wb_data);
    end
    checks++;
    if (o_chk_busy1 !== 1'b1) begin errors++; $display("FAIL alu_busy: got %b want 1", o_chk_busy1); end
    step(1'b1, 5'd0, 32'h0000_0055, 1'b0, 5'd0, 32'd0);
    checks++;
    if (o_wb_en !== 1'b0) begin errors++; $display("FAIL alu_x0: got en=%b want 0", o_wb_en); end
    idle();
  endtask

  task automatic test_load();
    i_chk_reg1 = 5'd7;
    i_chk_reg2 = 5'd8;
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_1234);
    checks++;
    if (o_chk_busy1 !== 1'b1 || o_chk_busy2 !== 1'b0) begin
      errors++; $display("FAIL load_busy_queued: got b1=%b b2=%b want 1 0", o_chk_busy1, o_chk_busy2);
    end
    checks++;
    if (o_wb_en !== 1'b0) begin errors++; $display("FAIL load_latency: got en=%b want 0 one cycle after accept", o_wb_en); end
    idle();
    checks++;
    if (o_wb_en !== 1'b1 || o_wb_reg !== 5'd7 || o_wb_data !== 32'h0000_1234) begin
      errors++; $display("FAIL load_write: got en=%b reg=%0d data=%h want 1 7 00001234", o_wb_en, o_wb_reg, o_wb_data);
    end
    checks++;
    if (o_chk_busy1 !== 1'b1) begin errors++; $display("FAIL load_busy_wb: got %b want 1", o_chk_busy1); end
    idle();
    checks++;
    if (o_chk_busy1 !== 1'b0 || o_wb_en !== 1'b0) begin
      errors++; $display("FAIL load_busy_clear: got busy=%b en=%b want 0 0", o_chk_busy1, o_wb_en);
    end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++)
      step(1'b1, 5'(10 + i), 32'hA000_0000 + 32'(i), 1'b1, 5'(i), 32'hC000_0000 + 32'(i));
    checks++;
    if (o_lq_count !== 3'd4 || o_lsu_ready !== 1'b0) begin
      errors++; $display("FAIL full_state: got count=%0d lsu_ready=%b want 4 0", o_lq_count, o_lsu_ready);
    end
    step(1'b1, 5'd15, 32'hA000_000F, 1'b1, 5'd5, 32'hC000_0005);
    checks++;
    if (o_wb_en !== 1'b1 || o_wb_reg !== 5'd1 || o_wb_data !== 32'hC000_0001) begin
      errors++; $display("FAIL full_pop: got en=%b reg=%0d data=%h want 1 1 c0000001", o_wb_en, o_wb_reg, o_wb_data);
    end
    step(1'b1, 5'd16, 32'hA000_0010, 1'b0, 5'd0, 32'd0);
    drain();
  endtask

  task automatic test_back_to_back();
    step(1'b1, 5'd17, 32'hA000_0011, 1'b1, 5'd21, 32'hB000_0015);
    step(1'b1, 5'd18, 32'hA000_0012, 1'b1, 5'd22, 32'hB000_0016);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd23, 32'hB000_0017);
    checks++;
    if (o_lq_count !== 3'd2) begin errors++; $display("FAIL simul_count: got %0d want 2", o_lq_count); end
    for (int i = 24; i <= 27; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'hB000_0000 + 32'(i));
    drain();
  endtask

  task automatic test_x0();
    i_chk_reg1 = 5'd0;
    i_chk_reg2 = 5'd0;
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    checks++;
    if (o_chk_busy1 !== 1'b0 || o_chk_busy2 !== 1'b0) begin
      errors++; $display("FAIL x0_busy: got b1=%b b2=%b want 0 0", o_chk_busy1, o_chk_busy2);
    end
    idle();
    checks++;
    if (o_wb_en !== 1'b0) begin errors++; $display("FAIL x0_write: got en=%b want 0", o_wb_en); end
    idle();
  endtask

  task automatic test_reset_mid();
    i_chk_reg1 = 5'd1;
    for (int i = 1; i <= 3; i++)
      step(1'b1, 5'(10 + i), 32'hE000_0000 + 32'(i), 1'b1, 5'(i), 32'hD000_0000 + 32'(i));
    i_alu_valid = 1'b0;
    i_lsu_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_wb_en !== 1'b0 || o_lq_count !== 3'd0) begin
      errors++; $display("FAIL midreset_state: got en=%b count=%0d want 0 0", o_wb_en, o_lq_count);
    end
    checks++;
    if (o_alu_ready !== 1'b1 || o_lsu_ready !== 1'b1 || o_chk_busy1 !== 1'b0) begin
      errors++; $display("FAIL midreset_ready: got alu=%b lsu=%b busy=%b want 1 1 0", o_alu_ready, o_lsu_ready, o_chk_busy1);
    end
    alu_q.delete();
    lsu_q.delete();
    cnt_m = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) idle();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_full();
    test_back_to_back();
    test_x0();
    test_reset_mid();
    checks++;
    if (alu_q.size() != 0) begin errors++; $display("FAIL alu_missing: got %0d unwritten want 0", alu_q.size()); end
    checks++;
    if (lsu_q.size() != 0) begin errors++; $display("FAIL lsu_missing: got %0d unwritten want 0", lsu_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
